fifo_traffic_gen: RTL

FIFO_TRAFFIC_GEN -- requirements
Module: fifo_traffic_gen

---
 rtl/fifo_traffic_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fifo_traffic_gen.sv
// Stream traffic generator/checker for a FIFO: sends BASE, BASE+1, ... on the enqueue side
// and checks that the dequeue side returns the same sequence, with an idle watchdog.
module fifo_traffic_gen #(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      COUNT   = 8,
    parameter logic [WIDTH-1:0] BASE    = 8'hA0,
    parameter int unsigned      TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    output logic             enq_val,
    output logic [WIDTH-1:0] enq_data,
    input  logic             enq_rdy,
    input  logic             deq_val,
    input  logic [WIDTH-1:0] deq_data,
    output logic             deq_rdy,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [7:0]       err_cnt,
    output logic [WIDTH-1:0] first_err_data
);

    typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

    localparam logic [7:0]  LAST_IDX = 8'(COUNT - 1);
    localparam logic [15:0] WDOG_MAX = 16'(TIMEOUT);

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [7:0]       sent_q, sent_d;
    logic [7:0]       recv_q, recv_d;
    logic [15:0]      wdog_q, wdog_d;
    logic [WIDTH-1:0] enq_data_q, enq_data_d;
    logic [7:0]       err_q, err_d;
    logic [WIDTH-1:0] first_err_q, first_err_d;
    logic             timeout_q, timeout_d;
    logic             enq_val_q, enq_val_d;
    logic             deq_rdy_q, deq_rdy_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic enqFire, deqFire, mismatch;

    assign enqFire  = enq_val_q & enq_rdy;
    assign deqFire  = deq_rdy_q & deq_val;
    assign mismatch = (deq_data != (BASE + WIDTH'(recv_q)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            sent_q      <= '0;
            recv_q      <= '0;
            wdog_q      <= '0;
            enq_data_q  <= BASE;
            err_q       <= '0;
            first_err_q <= '0;
            timeout_q   <= 1'b0;
            enq_val_q   <= 1'b0;
            deq_rdy_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            sent_q      <= sent_d;
            recv_q      <= recv_d;
            wdog_q      <= wdog_d;
            enq_data_q  <= enq_data_d;
            err_q       <= err_d;
            first_err_q <= first_err_d;
            timeout_q   <= timeout_d;
            enq_val_q   <= enq_val_d;
            deq_rdy_q   <= deq_rdy_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    // Completion by the final dequeue outranks both the SEND->DRAIN move and the watchdog.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        sent_d      = sent_q;
        recv_d      = recv_q;
        wdog_d      = wdog_q;
        enq_data_d  = enq_data_q;
        err_d       = err_q;
        first_err_d = first_err_q;
        timeout_d   = timeout_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = SEND;
                    mode_d      = mode;
                    sent_d      = '0;
                    recv_d      = '0;
                    wdog_d      = '0;
                    enq_data_d  = BASE;
                    err_d       = '0;
                    first_err_d = '0;
                    timeout_d   = 1'b0;
                end
            end
            SEND, DRAIN: begin
                if (enqFire) begin
                    sent_d     = sent_q + 8'd1;
                    enq_data_d = enq_data_q + WIDTH'(1);
                end
                if (deqFire) begin
                    recv_d = recv_q + 8'd1;
                    if (mismatch) begin
                        if (err_q == 8'd0) first_err_d = deq_data;
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    end
                end
                wdog_d = (enqFire || deqFire) ? 16'd0 : wdog_q + 16'd1;
                if (deqFire && recv_q == LAST_IDX) begin
                    state_d = DONE;
                end else if (enqFire && sent_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else if (!enqFire && !deqFire && (wdog_q + 16'd1) == WDOG_MAX) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status flags are registered from the next state so outputs are pure flops.
    always_comb begin
        enq_val_d = (state_d == SEND);
        deq_rdy_d = (state_d == DRAIN) || (state_d == SEND && !mode_d);
        busy_d    = (state_d == SEND) || (state_d == DRAIN);
        done_d    = (state_d == DONE);
        pass_d    = (state_d == DONE) && (err_d == 8'd0) && !timeout_d;
    end

    assign enq_val        = enq_val_q;
    assign enq_data       = enq_data_q;
    assign deq_rdy        = deq_rdy_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_cnt        = err_q;
    assign first_err_data = first_err_q;

endmodule
